// File: rtl/outpipe.sv
// ---------------------------------------------------------------------------
// outpipe -- output deskew pipeline for the systolic array.
//
// The array emits each result row as a skewed wavefront: lane i becomes valid
// i cycles after lane 0. Lane i is delayed by N-1-i register stages, so all
// lanes of one wavefront reach the shared output register on the same edge.
// From there they leave as one aligned, registered word.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (clears data and control)
//   en         pipeline advance; 0 freezes every delay stage
//   in_valid   [N]     per-lane valid, skewed (bit i = lane i)
//   in_data    [N*W]   skewed lane data (lane i = bits [i*W +: W])
//   out_valid          aligned word valid, one cycle per word
//   out_data   [N*W]   aligned word (lane i = bits [i*W +: W])
//   align_err          sticky: a wavefront arrived with mixed lane valids
//   word_count [COUNT_W] words emitted, wraps silently
// ---------------------------------------------------------------------------
module outpipe #(
    parameter int N       = 4,
    parameter int W       = 4,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N-1:0]       in_valid,
    input  logic [N*W-1:0]     in_data,
    output logic               out_valid,
    output logic [N*W-1:0]     out_data,
    output logic               align_err,
    output logic [COUNT_W-1:0] word_count
);

    // Aligned view of all lanes at the output-register input.
    logic [N-1:0]   al_vld;
    logic [N*W-1:0] al_data;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam int D = N - 1 - gi;

        if (D == 0) begin : g_direct
            // Last lane is already the latest one; it feeds the output register directly.
            assign al_vld[gi]            = in_valid[gi];
            assign al_data[gi*W +: W]    = in_data[gi*W +: W];
        end else begin : g_dly
            // ---- delay stages: dat_p[0] is newest, dat_p[D-1] is aligned ----
            logic [W-1:0] dat_p [D];
            logic         vld_p [D];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) begin
                        dat_p[k] <= '0;
                        vld_p[k] <= 1'b0;
                    end
                end else if (en) begin
                    dat_p[0] <= in_data[gi*W +: W];
                    vld_p[0] <= in_valid[gi];
                    for (int k = 1; k < D; k++) begin
                        dat_p[k] <= dat_p[k-1];
                        vld_p[k] <= vld_p[k-1];
                    end
                end
            end

            assign al_vld[gi]         = vld_p[D-1];
            assign al_data[gi*W +: W] = dat_p[D-1];
        end
    end

    // ---- output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            align_err  <= 1'b0;
            word_count <= '0;
        end else if (en) begin
            if (&al_vld) begin
                out_valid  <= 1'b1;
                out_data   <= al_data;
                word_count <= word_count + COUNT_W'(1);
            end else begin
                // Empty beat or a partial (misaligned) wavefront: nothing is emitted.
                // A partial one is dropped and latched as an error.
                out_valid <= 1'b0;
                if (|al_vld) begin
                    align_err <= 1'b1;
                end
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
